// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC, instruction-memory handshake, one-entry skid buffer and IF/ID register.
module if_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcKeep,
    input  logic        ifKeep,
    input  logic        ifClear,
    input  logic        branchTaken,
    input  logic [15:0] branchTarget,
    input  logic        memBusy,
    input  logic        instReady,
    input  logic [15:0] instData,
    output logic [15:0] instAddr,
    output logic        instReq,
    output logic [15:0] ifInst,
    output logic [15:0] ifPc,
    output logic        ifValid,
    output logic        fetchStall
);
    localparam logic [0:0] REQ = 1'b0;
    localparam logic [0:0] BUF = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] if_inst_q, if_inst_d;
    logic [15:0] if_pc_q, if_pc_d;
    logic        if_valid_q, if_valid_d;
    logic [15:0] buf_inst_q, buf_inst_d;
    logic [15:0] buf_pc_q, buf_pc_d;
    logic        hs, redirect, fetch_stall;

    always_comb begin
        instReq     = rst && state_q == REQ && !memBusy;
        hs          = instReq && instReady;
        redirect    = branchTaken && !pcKeep;
        state_d     = state_q;
        pc_d        = pc_q;
        if_inst_d   = if_inst_q;
        if_pc_d     = if_pc_q;
        if_valid_d  = if_valid_q;
        buf_inst_d  = buf_inst_q;
        buf_pc_d    = buf_pc_q;
        fetch_stall = 1'b0;
        if (state_q == REQ) begin
            if (hs && !pcKeep) pc_d = pc_q + 16'd1;
            if (hs && !ifKeep) begin
                if_inst_d  = instData;
                if_pc_d    = pc_q + 16'd1;
                if_valid_d = 1'b1;
            end else if (hs) begin
                buf_inst_d = instData;
                buf_pc_d   = pc_q + 16'd1;
                state_d    = BUF;
            end else if (!ifKeep) begin
                if_inst_d   = NOP_INST;
                if_pc_d     = 16'd0;
                if_valid_d  = 1'b0;
                fetch_stall = rst;
            end
        end else if (!ifKeep) begin
            // Resume right after the parked word even if pcKeep froze the PC at capture.
            if_inst_d  = buf_inst_q;
            if_pc_d    = buf_pc_q;
            if_valid_d = 1'b1;
            state_d    = REQ;
            if (!ifClear) pc_d = buf_pc_q;
        end
        if (redirect) begin
            pc_d        = branchTarget;
            state_d     = REQ;
            if_inst_d   = if_inst_q;
            if_pc_d     = if_pc_q;
            if_valid_d  = if_valid_q;
            fetch_stall = 1'b0;
        end
        if (ifClear) begin
            if_inst_d   = NOP_INST;
            if_pc_d     = 16'd0;
            if_valid_d  = 1'b0;
            state_d     = REQ;
            fetch_stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= REQ;
            pc_q       <= RESET_PC;
            if_inst_q  <= NOP_INST;
            if_pc_q    <= 16'd0;
            if_valid_q <= 1'b0;
            buf_inst_q <= NOP_INST;
            buf_pc_q   <= 16'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_inst_q  <= if_inst_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
            buf_inst_q <= buf_inst_d;
            buf_pc_q   <= buf_pc_d;
        end
    end

    assign instAddr   = pc_q;
    assign ifInst     = if_inst_q;
    assign ifPc       = if_pc_q;
    assign ifValid    = if_valid_q;
    assign fetchStall = fetch_stall;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed scenario checks for the fetch stage; memory returns addr ^ KEY.
module tb_if_fetch_unit;
    localparam logic [15:0] NOP = 16'h0800;
    localparam logic [15:0] KEY = 16'h5A00;

    logic        clk = 1'b0;
    logic        rst, pcKeep, ifKeep, ifClear, branchTaken, memBusy, instReady;
    logic [15:0] branchTarget, instData, instAddr, ifInst, ifPc;
    logic        instReq, ifValid, fetchStall;
    int          checks = 0;
    int          failures = 0;

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .pcKeep(pcKeep), .ifKeep(ifKeep), .ifClear(ifClear),
        .branchTaken(branchTaken), .branchTarget(branchTarget), .memBusy(memBusy),
        .instReady(instReady), .instData(instData), .instAddr(instAddr), .instReq(instReq),
        .ifInst(ifInst), .ifPc(ifPc), .ifValid(ifValid), .fetchStall(fetchStall)
    );

    always #5 clk = ~clk;
    assign instData = instAddr ^ KEY;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; instReady = 1'b1; memBusy = 1'b0;
        @(negedge clk);
        checks++; if (instReq !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", instReq); end
        checks++; if (fetchStall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", fetchStall); end
        tick();
        checks++; if (ifInst !== NOP) begin failures++; $display("FAIL rst_inst got=%h exp=%h", ifInst, NOP); end
        checks++; if (ifValid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", ifValid); end
        checks++; if (ifPc !== 16'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", ifPc); end
        checks++; if (instAddr !== 16'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", instAddr); end
    endtask

    task automatic test_stream;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (instAddr !== 16'(i)) begin failures++; $display("FAIL stream_addr got=%h exp=%h", instAddr, 16'(i)); end
            checks++; if (instReq !== 1'b1) begin failures++; $display("FAIL stream_req got=%b exp=1", instReq); end
            tick();
            checks++; if (ifPc !== 16'(i + 1)) begin failures++; $display("FAIL stream_ifpc got=%h exp=%h", ifPc, 16'(i + 1)); end
            checks++; if (ifInst !== (16'(i) ^ KEY)) begin failures++; $display("FAIL stream_inst got=%h exp=%h", ifInst, 16'(i) ^ KEY); end
            checks++; if (ifValid !== 1'b1) begin failures++; $display("FAIL stream_valid got=%b exp=1", ifValid); end
        end
    endtask

    task automatic test_mem_busy;
        memBusy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (instReq !== 1'b0) begin failures++; $display("FAIL busy_req got=%b exp=0", instReq); end
            checks++; if (fetchStall !== 1'b1) begin failures++; $display("FAIL busy_stall got=%b exp=1", fetchStall); end
            checks++; if (instAddr !== 16'h5) begin failures++; $display("FAIL busy_addr got=%h exp=5", instAddr); end
            tick();
            checks++; if (ifInst !== NOP) begin failures++; $display("FAIL busy_inst got=%h exp=%h", ifInst, NOP); end
            checks++; if (ifValid !== 1'b0) begin failures++; $display("FAIL busy_valid got=%b exp=0", ifValid); end
        end
        memBusy = 1'b0;
        @(negedge clk);
        checks++; if (instReq !== 1'b1) begin failures++; $display("FAIL busy_resume_req got=%b exp=1", instReq); end
        checks++; if (fetchStall !== 1'b0) begin failures++; $display("FAIL busy_resume_stall got=%b exp=0", fetchStall); end
        tick();
        checks++; if (ifPc !== 16'h6) begin failures++; $display("FAIL busy_resume_ifpc got=%h exp=6", ifPc); end
        checks++; if (ifInst !== (16'h5 ^ KEY)) begin failures++; $display("FAIL busy_resume_inst got=%h exp=%h", ifInst, 16'h5 ^ KEY); end
    endtask

    task automatic test_skid;
        tick();
        tick();
        ifKeep = 1'b1; pcKeep = 1'b1;
        @(negedge clk);
        checks++; if (instAddr !== 16'h8) begin failures++; $display("FAIL skid_addr got=%h exp=8", instAddr); end
        tick();
        checks++; if (ifPc !== 16'h8) begin failures++; $display("FAIL skid_hold_pc got=%h exp=8", ifPc); end
        checks++; if (ifInst !== (16'h7 ^ KEY)) begin failures++; $display("FAIL skid_hold_inst got=%h exp=%h", ifInst, 16'h7 ^ KEY); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (instReq !== 1'b0) begin failures++; $display("FAIL skid_buf_req got=%b exp=0", instReq); end
            tick();
            checks++; if (ifPc !== 16'h8) begin failures++; $display("FAIL skid_buf_ifpc got=%h exp=8", ifPc); end
        end
        ifKeep = 1'b0; pcKeep = 1'b0;
        @(negedge clk);
        checks++; if (instReq !== 1'b0) begin failures++; $display("FAIL skid_drain_req got=%b exp=0", instReq); end
        tick();
        checks++; if (ifInst !== (16'h8 ^ KEY)) begin failures++; $display("FAIL skid_drain_inst got=%h exp=%h", ifInst, 16'h8 ^ KEY); end
        checks++; if (ifPc !== 16'h9) begin failures++; $display("FAIL skid_drain_ifpc got=%h exp=9", ifPc); end
        checks++; if (ifValid !== 1'b1) begin failures++; $display("FAIL skid_drain_valid got=%b exp=1", ifValid); end
        @(negedge clk);
        checks++; if (instAddr !== 16'h9) begin failures++; $display("FAIL skid_next_addr got=%h exp=9", instAddr); end
        checks++; if (instReq !== 1'b1) begin failures++; $display("FAIL skid_next_req got=%b exp=1", instReq); end
        tick();
        checks++; if (ifPc !== 16'hA) begin failures++; $display("FAIL skid_next_ifpc got=%h exp=a", ifPc); end
    endtask

    task automatic test_flush_buf;
        ifKeep = 1'b1;
        tick();
        checks++; if (ifPc !== 16'hA) begin failures++; $display("FAIL flush_hold_ifpc got=%h exp=a", ifPc); end
        ifKeep = 1'b0; ifClear = 1'b1; branchTaken = 1'b1; branchTarget = 16'h0040;
        @(negedge clk);
        checks++; if (instReq !== 1'b0) begin failures++; $display("FAIL flush_buf_req got=%b exp=0", instReq); end
        tick();
        checks++; if (ifInst !== NOP) begin failures++; $display("FAIL flush_inst got=%h exp=%h", ifInst, NOP); end
        checks++; if (ifValid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", ifValid); end
        ifClear = 1'b0; branchTaken = 1'b0; instReady = 1'b0;
        @(negedge clk);
        checks++; if (instAddr !== 16'h0040) begin failures++; $display("FAIL flush_addr got=%h exp=0040", instAddr); end
        checks++; if (instReq !== 1'b1) begin failures++; $display("FAIL flush_req got=%b exp=1", instReq); end
        tick();
        checks++; if (ifValid !== 1'b0) begin failures++; $display("FAIL flush_noleak got=%b exp=0", ifValid); end
        instReady = 1'b1;
        tick();
        checks++; if (ifPc !== 16'h0041) begin failures++; $display("FAIL flush_ifpc got=%h exp=0041", ifPc); end
        checks++; if (ifInst !== (16'h0040 ^ KEY)) begin failures++; $display("FAIL flush_fetch got=%h exp=%h", ifInst, 16'h0040 ^ KEY); end
    endtask

    task automatic test_branch_keep;
        pcKeep = 1'b1; ifKeep = 1'b1; branchTaken = 1'b1; branchTarget = 16'h0080; instReady = 1'b0;
        tick();
        pcKeep = 1'b0; ifKeep = 1'b0;
        @(negedge clk);
        checks++; if (instAddr !== 16'h0041) begin failures++; $display("FAIL bkeep_ignored got=%h exp=0041", instAddr); end
        tick();
        branchTaken = 1'b0;
        @(negedge clk);
        checks++; if (instAddr !== 16'h0080) begin failures++; $display("FAIL bkeep_taken got=%h exp=0080", instAddr); end
    endtask

    task automatic test_wrap;
        branchTaken = 1'b1; branchTarget = 16'hFFFF; ifClear = 1'b1; instReady = 1'b1;
        tick();
        checks++; if (ifValid !== 1'b0) begin failures++; $display("FAIL wrap_discard got=%b exp=0", ifValid); end
        branchTaken = 1'b0; ifClear = 1'b0;
        @(negedge clk);
        checks++; if (instAddr !== 16'hFFFF) begin failures++; $display("FAIL wrap_addr got=%h exp=ffff", instAddr); end
        tick();
        checks++; if (ifPc !== 16'h0000) begin failures++; $display("FAIL wrap_ifpc got=%h exp=0000", ifPc); end
        checks++; if (ifInst !== (16'hFFFF ^ KEY)) begin failures++; $display("FAIL wrap_inst got=%h exp=%h", ifInst, 16'hFFFF ^ KEY); end
        @(negedge clk);
        checks++; if (instAddr !== 16'h0000) begin failures++; $display("FAIL wrap_pc got=%h exp=0000", instAddr); end
    endtask

    task automatic test_reset_mid;
        ifKeep = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (instReq !== 1'b0) begin failures++; $display("FAIL rmid_req got=%b exp=0", instReq); end
        tick();
        rst = 1'b1; ifKeep = 1'b0;
        checks++; if (ifValid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", ifValid); end
        checks++; if (ifInst !== NOP) begin failures++; $display("FAIL rmid_inst got=%h exp=%h", ifInst, NOP); end
        checks++; if (instAddr !== 16'h0) begin failures++; $display("FAIL rmid_addr got=%h exp=0", instAddr); end
        @(negedge clk);
        checks++; if (instReq !== 1'b1) begin failures++; $display("FAIL rmid_state got=%b exp=1", instReq); end
        tick();
        checks++; if (ifPc !== 16'h1) begin failures++; $display("FAIL rmid_ifpc got=%h exp=1", ifPc); end
    endtask

    initial begin
        rst = 1'b0; pcKeep = 1'b0; ifKeep = 1'b0; ifClear = 1'b0; branchTaken = 1'b0;
        branchTarget = 16'h0; memBusy = 1'b0; instReady = 1'b0;
        tick();
        test_reset();
        test_stream();
        test_mem_busy();
        test_skid();
        test_flush_buf();
        test_branch_keep();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
